pulse_gen_multi: RTL and testbench

//  Parametrised multi-channel pulse generator: successor to the fixed toggle-divider/XNOR pulse

---
 rtl/pulse_gen_multi_if.sv | 30 +++
 rtl/pulse_gen_multi.sv | 155 +++++++++++++++
 tb/tb_pulse_gen_multi.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/pulse_gen_multi_if.sv
// Control, shadow-config write port and per-channel pulse/status outputs of pulse_gen_multi.
interface pulse_gen_multi_if #(
  parameter int unsigned NCH   = 4,
  parameter int unsigned CNT_W = 16
);
  localparam int unsigned SEL_W = (NCH > 1) ? $clog2(NCH) : 1;

  logic [NCH-1:0]   ch_en;
  logic [NCH-1:0]   trig;
  logic             cfg_we;
  logic [SEL_W-1:0] cfg_sel;
  logic [CNT_W-1:0] cfg_period;
  logic [CNT_W-1:0] cfg_width;
  logic [CNT_W-1:0] cfg_delay;
  logic [1:0]       cfg_mode;
  logic [CNT_W-1:0] cfg_burst;
  logic [NCH-1:0]   pulse_out;
  logic [NCH-1:0]   busy;
  logic [NCH-1:0]   done;

  modport master (
    output ch_en, trig, cfg_we, cfg_sel, cfg_period, cfg_width, cfg_delay, cfg_mode, cfg_burst,
    input  pulse_out, busy, done
  );

  modport slave (
    input  ch_en, trig, cfg_we, cfg_sel, cfg_period, cfg_width, cfg_delay, cfg_mode, cfg_burst,
    output pulse_out, busy, done
  );
endinterface

// File: rtl/pulse_gen_multi.sv
// Multi-channel pulse generator: per-channel period/width/delay/mode with double-buffered config.
// Each channel runs an IDLE/DELAY/HIGH/LOW FSM; all outputs are registered from next-state.
module pulse_gen_multi #(
  parameter int unsigned NCH   = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  pulse_gen_multi_if.slave bus
);
  localparam int unsigned SEL_W = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {IDLE, DELAY, HIGH, LOW} state_t;

  typedef struct packed {
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] width;
    logic [CNT_W-1:0] delay;
    logic [1:0]       mode;
    logic [CNT_W-1:0] burst;
  } cfg_t;

  localparam cfg_t CFG_RST = '{period: CNT_W'(2), width: CNT_W'(1), delay: CNT_W'(0),
                               mode: 2'd0, burst: CNT_W'(1)};

  state_t           state     [NCH];
  state_t           state_nxt [NCH];
  cfg_t             shadow    [NCH];
  cfg_t             active    [NCH];
  cfg_t             active_nxt[NCH];
  cfg_t             ld        [NCH];
  logic [CNT_W-1:0] cnt       [NCH];
  logic [CNT_W-1:0] cnt_nxt   [NCH];
  logic [CNT_W-1:0] bcnt      [NCH];
  logic [CNT_W-1:0] bcnt_nxt  [NCH];
  logic [CNT_W-1:0] hlen      [NCH];
  logic [NCH-1:0]   pend;
  logic [NCH-1:0]   pulse_nxt, busy_nxt, done_nxt;
  logic [NCH-1:0]   pulse_q, busy_q, done_q;

  // Shadow value as it would land in the active set: P>=2, N>=1.
  function automatic cfg_t clamp(input cfg_t c);
    cfg_t r;
    r = c;
    if (c.period < CNT_W'(2)) r.period = CNT_W'(2);
    if (c.burst == '0)        r.burst  = CNT_W'(1);
    return r;
  endfunction

  // A period opens low when the programmed width is zero.
  function automatic state_t first_state(input cfg_t c);
    return (c.width == '0) ? LOW : HIGH;
  endfunction

  // State, counters and config registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(NCH); i++) begin
        state[i]  <= IDLE;
        cnt[i]    <= '0;
        bcnt[i]   <= '0;
        shadow[i] <= CFG_RST;
        active[i] <= CFG_RST;
      end
      pulse_q <= '0;
      busy_q  <= '0;
      done_q  <= '0;
    end else begin
      for (int i = 0; i < int'(NCH); i++) begin
        state[i]  <= state_nxt[i];
        cnt[i]    <= cnt_nxt[i];
        bcnt[i]   <= bcnt_nxt[i];
        active[i] <= active_nxt[i];
      end
      if (bus.cfg_we && (32'(bus.cfg_sel) < NCH)) begin
        shadow[bus.cfg_sel] <= '{period: bus.cfg_period, width: bus.cfg_width,
                                 delay: bus.cfg_delay, mode: bus.cfg_mode,
                                 burst: bus.cfg_burst};
      end
      pulse_q <= pulse_nxt;
      busy_q  <= busy_nxt;
      done_q  <= done_nxt;
    end
  end

  // Per-channel next-state, counter and load logic.
  always_comb begin
    for (int i = 0; i < int'(NCH); i++) begin
      state_nxt[i]  = state[i];
      cnt_nxt[i]    = cnt[i] + CNT_W'(1);
      bcnt_nxt[i]   = bcnt[i];
      active_nxt[i] = active[i];
      done_nxt[i]   = 1'b0;
      pend[i]       = 1'b0;
      ld[i]         = clamp(shadow[i]);
      hlen[i]       = (active[i].width >= active[i].period) ? active[i].period : active[i].width;

      unique case (state[i])
        IDLE: begin
          cnt_nxt[i] = '0;
          if (bus.trig[i] && bus.ch_en[i] && (shadow[i].mode != 2'd3)) begin
            active_nxt[i] = ld[i];
            bcnt_nxt[i]   = '0;
            state_nxt[i]  = (ld[i].delay != '0) ? DELAY : first_state(ld[i]);
          end
        end
        DELAY: begin
          if (cnt[i] == active[i].delay - CNT_W'(1)) begin
            cnt_nxt[i]   = '0;
            state_nxt[i] = first_state(active[i]);
          end
        end
        HIGH: begin
          if (cnt[i] == hlen[i] - CNT_W'(1)) begin
            cnt_nxt[i] = '0;
            if (active[i].width >= active[i].period) pend[i] = 1'b1;
            else                                     state_nxt[i] = LOW;
          end
        end
        LOW: begin
          if (cnt[i] == active[i].period - active[i].width - CNT_W'(1)) pend[i] = 1'b1;
        end
      endcase

      // Period end: continuous reloads from shadow, burst counts, anything else finishes.
      if (pend[i]) begin
        cnt_nxt[i] = '0;
        if (active[i].mode == 2'd0) begin
          active_nxt[i] = ld[i];
          state_nxt[i]  = first_state(ld[i]);
        end else if ((active[i].mode == 2'd2) && (bcnt[i] != active[i].burst - CNT_W'(1))) begin
          bcnt_nxt[i]  = bcnt[i] + CNT_W'(1);
          state_nxt[i] = first_state(active[i]);
        end else begin
          state_nxt[i] = IDLE;
          done_nxt[i]  = 1'b1;
        end
      end

      // Enable drop aborts silently.
      if ((state[i] != IDLE) && !bus.ch_en[i]) begin
        state_nxt[i] = IDLE;
        cnt_nxt[i]   = '0;
        done_nxt[i]  = 1'b0;
      end

      pulse_nxt[i] = (state_nxt[i] == HIGH);
      busy_nxt[i]  = (state_nxt[i] != IDLE);
    end
  end

  assign bus.pulse_out = pulse_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
endmodule

// File: tb/tb_pulse_gen_multi.sv
// Directed bench for pulse_gen_multi: period-position model checked every cycle plus literal pins.
module tb_pulse_gen_multi;
  localparam int NCH   = 4;
  localparam int CNT_W = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pulse_gen_multi_if #(.NCH(NCH), .CNT_W(CNT_W)) bus ();

  pulse_gen_multi #(.NCH(NCH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_on   = 1'b0;

  // Model: shadow/active config, running flag, remaining delay, position in period, periods done.
  int sp[NCH], sw[NCH], sd[NCH], sm[NCH], sn[NCH];
  int ap[NCH], aw[NCH], ad[NCH], am[NCH], an[NCH];
  bit run[NCH];
  int dly[NCH], pos[NCH], np[NCH];
  logic [NCH-1:0] e_pulse = '0, e_busy = '0, e_done = '0;

  function automatic void mload(int c);
    ap[c] = (sp[c] < 2) ? 2 : sp[c];
    aw[c] = sw[c];
    ad[c] = sd[c];
    am[c] = sm[c];
    an[c] = (sn[c] == 0) ? 1 : sn[c];
  endfunction

  always @(posedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      if (reset) begin
        sp[c] = 2; sw[c] = 1; sd[c] = 0; sm[c] = 0; sn[c] = 1;
        mload(c);
        run[c] = 1'b0; dly[c] = 0; pos[c] = 0; np[c] = 0;
        e_done[c] = 1'b0;
      end else begin
        e_done[c] = 1'b0;
        if (run[c]) begin
          if (!bus.ch_en[c]) run[c] = 1'b0;
          else if (dly[c] > 0) dly[c]--;
          else begin
            pos[c]++;
            if (pos[c] == ap[c]) begin
              np[c]++;
              pos[c] = 0;
              if (am[c] == 0) mload(c);
              else if (!(am[c] == 2 && np[c] < an[c])) begin
                run[c] = 1'b0;
                e_done[c] = 1'b1;
              end
            end
          end
        end else if (bus.trig[c] && bus.ch_en[c] && sm[c] != 3) begin
          mload(c);
          run[c] = 1'b1; dly[c] = ad[c]; pos[c] = 0; np[c] = 0;
        end
        if (bus.cfg_we && int'(bus.cfg_sel) == c) begin
          sp[c] = int'(bus.cfg_period); sw[c] = int'(bus.cfg_width);
          sd[c] = int'(bus.cfg_delay);  sm[c] = int'(bus.cfg_mode);
          sn[c] = int'(bus.cfg_burst);
        end
      end
      e_busy[c]  = run[c];
      e_pulse[c] = run[c] && (dly[c] == 0) && (pos[c] < aw[c]);
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t actual=%h expected=%h", name, $time, act, exp);
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("pulse_out", 32'(bus.pulse_out), 32'(e_pulse));
      chk("busy",      32'(bus.busy),      32'(e_busy));
      chk("done",      32'(bus.done),      32'(e_done));
    end
  end

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cfg(int c, int p, int w, int d, int m, int n);
    bus.cfg_we = 1'b1;     bus.cfg_sel = 2'(c);
    bus.cfg_period = 16'(p); bus.cfg_width = 16'(w); bus.cfg_delay = 16'(d);
    bus.cfg_mode = 2'(m);  bus.cfg_burst = 16'(n);
    tick(1);
    bus.cfg_we = 1'b0;
  endtask

  task automatic fire(int c);
    bus.trig = 4'(1 << c);
    tick(1);
    bus.trig = '0;
  endtask

  logic [31:0] seq, mseq, dseq, bseq;
  logic        acc;

  initial begin
    reset = 1'b1;
    bus.ch_en = '0; bus.trig = '0; bus.cfg_we = 1'b0; bus.cfg_sel = '0;
    bus.cfg_period = '0; bus.cfg_width = '0; bus.cfg_delay = '0;
    bus.cfg_mode = '0; bus.cfg_burst = '0;
    @(posedge clk);
    chk_on = 1'b1;
    tick(2);
    chk("reset_pulse", 32'(bus.pulse_out), 32'h0);
    chk("reset_busy",  32'(bus.busy),      32'h0);
    reset = 1'b0;
    tick(1);

    // Continuous P=5 W=2 on ch0
    bus.ch_en = 4'b0001;
    cfg(0, 5, 2, 0, 0, 1);
    fire(0);
    seq = '0; mseq = '0;
    for (int i = 0; i < 10; i++) begin
      seq[i] = bus.pulse_out[0]; mseq[i] = e_pulse[0]; tick(1);
    end
    chk("t1_seq",   seq,  32'h063);
    chk("t1_model", mseq, 32'h063);

    // Live rewrite to P=8 W=4 at the first cycle of a period
    cfg(0, 8, 4, 0, 0, 1);
    seq = '0;
    for (int i = 0; i < 13; i++) begin
      seq[i] = bus.pulse_out[0]; tick(1);
    end
    chk("t3_seq", seq, 32'h10F1);
    bus.ch_en = 4'b0000;
    tick(1);
    chk("t3_off_busy", 32'(bus.busy[0]), 32'h0);

    // Burst P=4 W=1 D=3 N=3 on ch1
    bus.ch_en = 4'b0010;
    cfg(1, 4, 1, 3, 2, 3);
    fire(1);
    seq = '0; mseq = '0; dseq = '0; bseq = '0;
    for (int i = 0; i < 15; i++) begin
      seq[i] = bus.pulse_out[1]; mseq[i] = e_pulse[1];
      dseq[i] = bus.done[1]; bseq[i] = bus.busy[1];
      tick(1);
    end
    chk("t2_pulse", seq,  32'h0888);
    chk("t2_model", mseq, 32'h0888);
    chk("t2_done_early", dseq, 32'h0);
    chk("t2_busy", bseq, 32'h7FFF);
    chk("t2_done", 32'(bus.done[1]), 32'h1);
    chk("t2_done_busy", 32'(bus.busy[1]), 32'h0);
    fire(1);
    chk("t6_restart_busy", 32'(bus.busy[1]), 32'h1);
    fire(1);
    tick(2);
    chk("t6_restart_high", 32'(bus.pulse_out[1]), 32'h1);
    bus.ch_en = 4'b0000;
    tick(1);
    chk("t5_drop_pulse", 32'(bus.pulse_out[1]), 32'h0);
    chk("t5_drop_busy",  32'(bus.busy[1]),      32'h0);
    chk("t5_drop_done",  32'(bus.done[1]),      32'h0);
    tick(10);

    // W=0 then W=9 with P=6 continuous on ch2
    bus.ch_en = 4'b0100;
    cfg(2, 6, 0, 0, 0, 1);
    fire(2);
    acc = 1'b0;
    for (int i = 0; i < 12; i++) begin
      acc |= bus.pulse_out[2];
      chk("t4_w0_busy", 32'(bus.busy[2]), 32'h1);
      tick(1);
    end
    chk("t4_w0_low", 32'(acc), 32'h0);
    cfg(2, 6, 9, 0, 0, 1);
    tick(7);
    acc = 1'b1;
    for (int i = 0; i < 12; i++) begin
      acc &= bus.pulse_out[2]; tick(1);
    end
    chk("t4_w9_high", 32'(acc), 32'h1);

    // P=0 behaves as P=2 on ch3
    bus.ch_en = 4'b1100;
    cfg(3, 0, 1, 0, 0, 1);
    fire(3);
    seq = '0;
    for (int i = 0; i < 6; i++) begin
      seq[i] = bus.pulse_out[3]; tick(1);
    end
    chk("t4_p0_seq", seq, 32'h15);

    // Reset with ch2 high and ch3 toggling
    reset = 1'b1;
    tick(1);
    chk("t5_rst_pulse", 32'(bus.pulse_out), 32'h0);
    chk("t5_rst_busy",  32'(bus.busy),      32'h0);
    chk("t5_rst_done",  32'(bus.done),      32'h0);
    reset = 1'b0;
    bus.ch_en = 4'b0000;
    tick(2);

    // Mode 3 never runs; a trig coincident with a config write sees the old shadow
    bus.ch_en = 4'b0001;
    cfg(0, 5, 2, 0, 3, 1);
    fire(0);
    chk("t6_mode3_busy", 32'(bus.busy[0]), 32'h0);
    tick(4);
    chk("t6_mode3_idle", 32'(bus.busy[0]), 32'h0);
    bus.trig = 4'b0001;
    cfg(0, 5, 2, 0, 0, 1);
    bus.trig = '0;
    chk("t6_prewrite", 32'(bus.busy[0]), 32'h0);
    fire(0);
    chk("t6_postwrite", 32'(bus.busy[0]), 32'h1);
    chk("t6_postwrite_hi", 32'(bus.pulse_out[0]), 32'h1);
    tick(12);
    bus.ch_en = '0;
    tick(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
